// File: rtl/pll_reset_seq_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and sizing helpers.
// No logic, no latency, no flow control.
package pll_reset_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    REL_SHIFT = 3'd2,
    REL_PIXEL = 3'd3,
    RUN       = 3'd4
  } seq_state_e;

  // Bits needed to count 0..v-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(v)) w++;
    return w;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, cleared by synchronous reset.
// Latency STAGES cycles; no flow control.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock and releases shift, pixel, CPU resets in order; re-resets PLL on lock timeout.
// All outputs registered; optional loss counter via PLL_RESET_SEQUENCER_LOSS_COUNT_EN.
module pll_reset_sequencer
  import pll_reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 4096,
  parameter int unsigned STAGE_GAP_CYCLES    = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       locked_i,
  output logic       pll_reset_o,
  output logic       rst_shift_o,
  output logic       rst_pixel_o,
  output logic       rst_cpu_o,
  output logic       ready_o,
  output logic [2:0] state_o
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
  ,
  output logic [7:0] lock_loss_cnt_o
`endif
);

  if (SYNC_STAGES < 2 || PLL_RST_CYCLES == 0 || LOCK_STABLE_CYCLES == 0 ||
      STAGE_GAP_CYCLES == 0 || LOCK_TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("pll_reset_sequencer: illegal parameter value");
  end

  localparam int unsigned CW = cnt_width(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                              STAGE_GAP_CYCLES));
  localparam int unsigned TW = cnt_width(LOCK_TIMEOUT_CYCLES);

  localparam logic [CW-1:0] PRC_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);

  logic          locked_s;
  seq_state_e    state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(clki),
    .rst(rst),
    .d  (locked_i),
    .q  (locked_s)
  );

  // cnt is the per-state cycle counter; in WAIT_LOCK it doubles as the stable-lock run length.
  always_ff @(posedge clki) begin
    if (rst) begin
      state       <= PLL_RST;
      cnt         <= '0;
      tmo         <= '0;
      pll_reset_o <= 1'b1;
      rst_shift_o <= 1'b1;
      rst_pixel_o <= 1'b1;
      rst_cpu_o   <= 1'b1;
      ready_o     <= 1'b0;
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
      lock_loss_cnt_o <= 8'd0;
`endif
    end else begin
      unique case (state)
        PLL_RST: begin
          if (cnt == PRC_LAST) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            tmo         <= '0;
            pll_reset_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_LOCK: begin
          // Qualification is tested first so it wins a same-cycle tie with the timeout.
          if (locked_s && cnt == STB_LAST) begin
            state       <= REL_SHIFT;
            cnt         <= '0;
            tmo         <= '0;
            rst_shift_o <= 1'b0;
          end else if (tmo == TMO_LAST) begin
            state       <= PLL_RST;
            cnt         <= '0;
            tmo         <= '0;
            pll_reset_o <= 1'b1;
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
            lock_loss_cnt_o <= sat_inc8(lock_loss_cnt_o);
`endif
          end else begin
            tmo <= tmo + 1'b1;
            cnt <= locked_s ? cnt + 1'b1 : '0;
          end
        end

        REL_SHIFT, REL_PIXEL, RUN: begin
          if (!locked_s) begin
            // Lock lost: drop every domain back into reset together, but leave the PLL running.
            state       <= WAIT_LOCK;
            cnt         <= '0;
            tmo         <= '0;
            rst_shift_o <= 1'b1;
            rst_pixel_o <= 1'b1;
            rst_cpu_o   <= 1'b1;
            ready_o     <= 1'b0;
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
            lock_loss_cnt_o <= sat_inc8(lock_loss_cnt_o);
`endif
          end else if (state != RUN && cnt == GAP_LAST) begin
            cnt <= '0;
            if (state == REL_SHIFT) begin
              state       <= REL_PIXEL;
              rst_pixel_o <= 1'b0;
            end else begin
              state     <= RUN;
              rst_cpu_o <= 1'b0;
              ready_o   <= 1'b1;
            end
          end else if (state != RUN) begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state       <= PLL_RST;
          cnt         <= '0;
          tmo         <= '0;
          pll_reset_o <= 1'b1;
          rst_shift_o <= 1'b1;
          rst_pixel_o <= 1'b1;
          rst_cpu_o   <= 1'b1;
          ready_o     <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised and directed bench for pll_reset_sequencer against a timestamp-based reference model.
module tb_pll_reset_sequencer;

  localparam int SS  = 2;
  localparam int PRC = 4;
  localparam int STB = 8;
  localparam int GAP = 4;
  localparam int TMO = 64;

  logic       clki = 1'b0;
  logic       rst = 1'b1;
  logic       locked_i = 1'b0;
  logic       pll_reset_o, rst_shift_o, rst_pixel_o, rst_cpu_o, ready_o;
  logic [2:0] state_o;
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
  logic [7:0] lock_loss_cnt_o;
`endif

  int total = 0;
  int bad = 0;

  always #20 clki = ~clki;

  pll_reset_sequencer #(
    .SYNC_STAGES        (SS),
    .PLL_RST_CYCLES     (PRC),
    .LOCK_STABLE_CYCLES (STB),
    .STAGE_GAP_CYCLES   (GAP),
    .LOCK_TIMEOUT_CYCLES(TMO)
  ) dut (
    .clki       (clki),
    .rst        (rst),
    .locked_i   (locked_i),
    .pll_reset_o(pll_reset_o),
    .rst_shift_o(rst_shift_o),
    .rst_pixel_o(rst_pixel_o),
    .rst_cpu_o  (rst_cpu_o),
    .ready_o    (ready_o),
    .state_o    (state_o)
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
    ,
    .lock_loss_cnt_o(lock_loss_cnt_o)
`endif
  );

  // Reference model: phase plus the edge index at which it was entered; durations are edge differences.
  int   m_k = 0;
  int   m_ph = 0;
  int   m_k0 = 0;
  int   m_lastz = 0;
  int   m_lcnt = 0;
  bit   m_valid = 0;
  bit   hist_l[$];
  bit   hist_r[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", nm, m_k, act, exp);
    end
  endtask

  always @(posedge clki) begin : model
    bit ls;
    m_k++;
    // Lock as seen by the sequencer: the input from SS edges ago, unless a reset hit since then.
    ls = (hist_l.size() >= SS);
    for (int i = 0; i < SS && i < hist_r.size(); i++)
      if (hist_r[i]) ls = 0;
    if (ls) ls = hist_l[SS-1];
    hist_l.push_front(locked_i);
    hist_r.push_front(rst);
    if (hist_l.size() > SS) begin
      void'(hist_l.pop_back());
      void'(hist_r.pop_back());
    end
    if (rst) begin
      m_valid = 1;
      m_ph = 0; m_k0 = m_k; m_lastz = m_k; m_lcnt = 0;
    end else if (m_ph == 0) begin
      if (m_k - m_k0 == PRC) begin m_ph = 1; m_k0 = m_k; m_lastz = m_k; end
    end else if (m_ph == 1) begin
      if (!ls) m_lastz = m_k;
      if (m_k - m_lastz >= STB) begin
        m_ph = 2; m_k0 = m_k;
      end else if (m_k - m_k0 == TMO) begin
        m_ph = 0; m_k0 = m_k;
        if (m_lcnt < 255) m_lcnt++;
      end
    end else if (!ls) begin
      m_ph = 1; m_k0 = m_k; m_lastz = m_k;
      if (m_lcnt < 255) m_lcnt++;
    end else if (m_ph < 4 && m_k - m_k0 == GAP) begin
      m_ph++; m_k0 = m_k;
    end
  end

  always @(negedge clki) begin : compare
    if (m_valid) begin
      chk("pll_reset_o", 32'(pll_reset_o), 32'(m_ph == 0));
      chk("rst_shift_o", 32'(rst_shift_o), 32'(m_ph < 2));
      chk("rst_pixel_o", 32'(rst_pixel_o), 32'(m_ph < 3));
      chk("rst_cpu_o",   32'(rst_cpu_o),   32'(m_ph < 4));
      chk("ready_o",     32'(ready_o),     32'(m_ph == 4));
      chk("state_o",     32'(state_o),     32'(m_ph));
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
      chk("lock_loss_cnt_o", 32'(lock_loss_cnt_o), 32'(m_lcnt));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clki);
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return pll_reset_o;
      1:       return rst_shift_o;
      2:       return rst_pixel_o;
      3:       return rst_cpu_o;
      default: return ready_o;
    endcase
  endfunction

  // Counts falling clock edges until output sel equals val; -1 if the bound expires.
  task automatic wait_out(input int sel, input logic val, input int lim, input string nm,
                          output int n);
    n = 0;
    while (n < lim) begin
      step(1);
      n++;
      if (pick(sel) == val) return;
    end
    total++;
    bad++;
    $display("FAIL %s: output %0d never reached %0d within %0d cycles", nm, sel, val, lim);
    n = -1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    locked_i = 1'b0;
    step(3);
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_pll", 32'(pll_reset_o), 32'd1);
    chk("reset_ready", 32'(ready_o), 32'd0);
    rst = 1'b0;

    // Cold start: lock arrives 10 cycles after reset release.
    wait_out(0, 1'b0, 20, "cold_pll", n);
    chk("cold_pll_len", n, PRC);
    step(6);
    locked_i = 1'b1;
    wait_out(1, 1'b0, 40, "cold_shift", n);
    chk("cold_shift_delay", n, 10);
    wait_out(2, 1'b0, 20, "cold_pixel", n);
    chk("cold_pixel_delay", n, 4);
    wait_out(3, 1'b0, 20, "cold_cpu", n);
    chk("cold_cpu_delay", n, 4);
    chk("cold_ready", 32'(ready_o), 32'd1);
    chk("cold_state_run", 32'(state_o), 32'd4);

    // Loss of lock in RUN.
    step(5);
    locked_i = 1'b0;
    wait_out(1, 1'b1, 10, "loss_shift", n);
    chk("loss_delay", n, 3);
    chk("loss_state", 32'(state_o), 32'd1);
    chk("loss_pll_stays_low", 32'(pll_reset_o), 32'd0);
    chk("loss_ready", 32'(ready_o), 32'd0);
    chk("loss_cpu", 32'(rst_cpu_o), 32'd1);

    // Re-lock with a one-cycle glitch after six qualified cycles.
    locked_i = 1'b1;
    step(6);
    locked_i = 1'b0;
    step(1);
    locked_i = 1'b1;
    wait_out(1, 1'b0, 40, "glitch_shift", n);
    chk("glitch_shift_delay", 7 + n, 17);

    // Reset mid-sequence in REL_PIXEL.
    wait_out(2, 1'b0, 20, "relock_pixel", n);
    chk("relock_state_pixel", 32'(state_o), 32'd3);
    rst = 1'b1;
    locked_i = 1'b0;
    step(1);
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_pll", 32'(pll_reset_o), 32'd1);
    chk("midrst_shift", 32'(rst_shift_o), 32'd1);
    chk("midrst_pixel", 32'(rst_pixel_o), 32'd1);
    step(1);
    rst = 1'b0;

    // No lock: PLL reset re-pulses every PRC+TMO cycles.
    wait_out(0, 1'b0, 20, "nolock_first", n);
    chk("nolock_first_len", n, PRC);
    for (int i = 0; i < 2; i++) begin
      wait_out(0, 1'b1, TMO + 20, "nolock_timeout", n);
      chk("nolock_timeout_len", n, TMO);
      wait_out(0, 1'b0, 20, "nolock_pulse", n);
      chk("nolock_pulse_len", n, PRC);
    end
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
    chk("nolock_loss_cnt", 32'(lock_loss_cnt_o), 32'd2);
`endif

    // Random lock activity with occasional resets, checked every cycle by the model.
    for (int i = 0; i < 150; i++) begin
      locked_i = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) < 3);
      step(1);
      rst = 1'b0;
      step($urandom_range(1, 30));
    end

`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
    // Force 300 losses from REL_SHIFT; the counter must stop at 255.
    rst = 1'b1;
    locked_i = 1'b0;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      locked_i = 1'b1;
      wait_out(1, 1'b0, 40, "sat_shift", n);
      locked_i = 1'b0;
      wait_out(1, 1'b1, 10, "sat_loss", n);
    end
    chk("loss_cnt_saturated", 32'(lock_loss_cnt_o), 32'd255);
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
